ntt_agu: RTL

Address-generation and sequencing stage that sits directly upstream of the NTT butterfly `datapath`. On a start pulse it walks all stages of a 1024-point in-place NTT stored as 256 rows of 4×32-bit coefficients. For each butterfly row pair it issues SRAM read addresses, then presents `addr1`/`addr2`, stride, four twiddle offsets and valid to the datapath, aligned with the returning read data. It inserts drain gaps between stages so the datapath writes back each stage before the next stage reads it.

---
 rtl/ntt_agu.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ntt_agu.sv
// rtl/ntt_agu.sv - NTT address generator: walks stages/row pairs, issues SRAM reads
// and presents read-aligned addresses, stride and twiddle exponents to the butterfly datapath.
module ntt_agu #(
  parameter int READ_LAT     = 1,
  parameter int DRAIN_CYCLES = 7,
  parameter int NUM_STAGES   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_stall,
  output logic       o_mem_ren,
  output logic [7:0] o_mem_raddr1,
  output logic [7:0] o_mem_raddr2,
  output logic [7:0] o_addr1,
  output logic [7:0] o_addr2,
  output logic [9:0] o_stride,
  output logic [8:0] o_twiddle_offset1,
  output logic [8:0] o_twiddle_offset2,
  output logic [8:0] o_twiddle_offset3,
  output logic [8:0] o_twiddle_offset4,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  localparam logic [3:0] LAST_STAGE = 4'(NUM_STAGES - 1);

  state_t      r_state;
  logic [3:0]  r_stage;
  logic [6:0]  r_pair;
  logic [7:0]  r_drain;

  logic [9:0]  w_stride;
  logic [2:0]  w_lg_dist;
  logic [7:0]  w_dist;
  logic [7:0]  w_lo_mask;
  logic [7:0]  w_pair8;
  logic [7:0]  w_addr1;
  logic [7:0]  w_addr2;
  logic [8:0]  w_tw [4];
  logic        w_ren;
  logic [61:0] w_fields;

  logic        r_pv [READ_LAT];
  logic [61:0] r_pd [READ_LAT];

  // Row distance is 2^(7-s), bottoming out at one row from stage 7 onward.
  assign w_stride  = 10'd512 >> r_stage;
  assign w_lg_dist = (r_stage < 4'd7) ? 3'(4'd7 - r_stage) : 3'd0;
  assign w_dist    = 8'd1 << w_lg_dist;
  assign w_lo_mask = w_dist - 8'd1;
  assign w_pair8   = {1'b0, r_pair};
  assign w_addr1   = (w_pair8 & w_lo_mask) | ((w_pair8 & ~w_lo_mask) << 1);
  assign w_addr2   = w_addr1 + w_dist;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_tw[k] = 9'(({w_addr1, 2'(k)} & (w_stride - 10'd1)) << r_stage);
    end
  end

  assign w_ren    = (r_state == S_ISSUE) && !i_stall;
  assign w_fields = {w_addr1, w_addr2, w_stride, w_tw[0], w_tw[1], w_tw[2], w_tw[3]};

  assign o_mem_ren    = w_ren;
  assign o_mem_raddr1 = w_ren ? w_addr1 : 8'd0;
  assign o_mem_raddr2 = w_ren ? w_addr2 : 8'd0;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_stage <= 4'd0;
      r_pair  <= 7'd0;
      r_drain <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_ISSUE;
            r_stage <= 4'd0;
            r_pair  <= 7'd0;
          end
        end
        S_ISSUE: begin
          if (!i_stall) begin
            r_pair <= r_pair + 7'd1;
            if (r_pair == 7'd127) begin
              r_state <= S_DRAIN;
              r_drain <= 8'd0;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            r_drain <= 8'd0;
            if (r_stage == LAST_STAGE) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_ISSUE;
              r_stage <= r_stage + 4'd1;
            end
          end else begin
            r_drain <= r_drain + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_stage <= 4'd0;
        end
      endcase
    end
  end

  // Fields only load alongside a valid so they hold their last value across gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pd[i] <= '0;
      end
    end else begin
      r_pv[0] <= w_ren;
      if (w_ren) r_pd[0] <= w_fields;
      for (int i = 1; i < READ_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign o_valid = r_pv[READ_LAT-1];
  assign {o_addr1, o_addr2, o_stride, o_twiddle_offset1, o_twiddle_offset2,
          o_twiddle_offset3, o_twiddle_offset4} = r_pd[READ_LAT-1];

endmodule
